// File: rtl/booth_seq_multiplier_pkg.sv
// Shared types and size helpers for the iterative Booth multiplier.
package booth_pkg;

    typedef enum logic [2:0] {
        BOOTH_NOP  = 3'b000,
        BOOTH_ADD1 = 3'b001,
        BOOTH_ADD2 = 3'b010,
        BOOTH_SUB1 = 3'b101,
        BOOTH_SUB2 = 3'b110
    } booth_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } booth_state_t;

    // Two guard bits make zero-extended unsigned operands exact signed values
    function automatic int ext_width(input int width);
        return width + 2;
    endfunction

    function automatic int iter_count(input int width, input int radix4);
        return (radix4 != 0) ? (width + 2) / 2 : width + 2;
    endfunction

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// Start/busy/done handshake and operand/result bus of the Booth multiplier.
interface booth_seq_multiplier_if import booth_pkg::*; #(parameter int WIDTH = 32);
    logic               start;
    logic               op_signed;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;
    booth_op_t          booth_op;

    modport master (
        output start, op_signed, multiplicand, multiplier,
        input  busy, done, product, booth_op
    );

    modport slave (
        input  start, op_signed, multiplicand, multiplier,
        output busy, done, product, booth_op
    );
endinterface

// File: rtl/booth_seq_multiplier_recoder.sv
// Booth digit recoder: maps the low multiplier bits {q1,q0,q-1} to an add/sub decision.
module booth_recoder import booth_pkg::*; #(
    parameter int RADIX4 = 0
) (
    input  logic [2:0] lsb_bits,
    output booth_op_t  op
);

    // Radix-4 looks at all three bits, radix-2 only at {q0,q-1}
    always_comb begin
        op = BOOTH_NOP;
        if (RADIX4 != 0) begin
            case (lsb_bits)
                3'b001, 3'b010: op = BOOTH_ADD1;
                3'b011:         op = BOOTH_ADD2;
                3'b100:         op = BOOTH_SUB2;
                3'b101, 3'b110: op = BOOTH_SUB1;
                default:        op = BOOTH_NOP;
            endcase
        end else begin
            case (lsb_bits[1:0])
                2'b01:   op = BOOTH_ADD1;
                2'b10:   op = BOOTH_SUB1;
                default: op = BOOTH_NOP;
            endcase
        end
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-2/radix-4 Booth multiplier with start/busy/done handshake.
module booth_seq_multiplier import booth_pkg::*; #(
    parameter int WIDTH  = 32,
    parameter int RADIX4 = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    booth_seq_multiplier_if.slave  bus
);

    localparam int EXT  = ext_width(WIDTH);
    localparam int AW   = EXT + 2;
    localparam int TW   = AW + EXT + 1;
    localparam int ITER = iter_count(WIDTH, RADIX4);
    localparam int CW   = $clog2(ITER) + 1;
    localparam int SH   = (RADIX4 != 0) ? 2 : 1;

    booth_state_t       state_r;
    logic [CW-1:0]      cnt_r;
    logic [EXT-1:0]     m_r;
    logic [EXT-1:0]     q_r;
    logic [AW-1:0]      a_r;
    logic               qm1_r;
    booth_op_t          op_r;
    logic               busy_r;
    logic               done_r;
    logic [2*WIDTH-1:0] product_r;

    logic [EXT-1:0]     m_ext_s;
    logic [EXT-1:0]     q_ext_s;
    logic [AW-1:0]      m_a_s;
    logic [AW-1:0]      m2_a_s;
    logic [AW-1:0]      sum_s;
    logic [TW-1:0]      full_s;
    logic [TW-1:0]      shifted_s;
    logic [2:0]         rec_in_s;
    booth_op_t          rec_op_s;
    logic               last_s;

    assign m_ext_s = bus.op_signed ? {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand}
                                   : {2'b00, bus.multiplicand};
    assign q_ext_s = bus.op_signed ? {{2{bus.multiplier[WIDTH-1]}}, bus.multiplier}
                                   : {2'b00, bus.multiplier};
    assign m_a_s   = {{2{m_r[EXT-1]}}, m_r};
    assign m2_a_s  = {m_a_s[AW-2:0], 1'b0};
    assign last_s  = (cnt_r == {CW{1'b0}});

    // Accumulate the decision held in op_r, which always matches the current Q LSBs
    always_comb begin
        sum_s = a_r;
        case (op_r)
            BOOTH_ADD1: sum_s = a_r + m_a_s;
            BOOTH_ADD2: sum_s = a_r + m2_a_s;
            BOOTH_SUB1: sum_s = a_r - m_a_s;
            BOOTH_SUB2: sum_s = a_r - m2_a_s;
            default:    sum_s = a_r;
        endcase
    end

    assign full_s    = {sum_s, q_r, qm1_r};
    assign shifted_s = $signed(full_s) >>> SH;

    // Recode the bits that will sit at the bottom next cycle, so booth_op is registered
    assign rec_in_s = (state_r == ST_RUN) ? shifted_s[2:0] : {q_ext_s[1:0], 1'b0};

    booth_recoder #(.RADIX4(RADIX4)) u_recoder (
        .lsb_bits (rec_in_s),
        .op       (rec_op_s)
    );

    // Control FSM, operand/accumulator registers and product capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            m_r       <= {EXT{1'b0}};
            q_r       <= {EXT{1'b0}};
            a_r       <= {AW{1'b0}};
            qm1_r     <= 1'b0;
            op_r      <= BOOTH_NOP;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r <= ST_RUN;
                        busy_r  <= 1'b1;
                        m_r     <= m_ext_s;
                        q_r     <= q_ext_s;
                        a_r     <= {AW{1'b0}};
                        qm1_r   <= 1'b0;
                        cnt_r   <= CW'(ITER - 1);
                        op_r    <= rec_op_s;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        op_r    <= BOOTH_NOP;
                    end
                end
                ST_RUN: begin
                    a_r   <= shifted_s[TW-1 -: AW];
                    q_r   <= shifted_s[EXT:1];
                    qm1_r <= shifted_s[0];
                    cnt_r <= cnt_r - CW'(1);
                    if (last_s) begin
                        state_r   <= ST_DONE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        product_r <= shifted_s[2*WIDTH:1];
                        op_r      <= BOOTH_NOP;
                    end else begin
                        op_r <= rec_op_s;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    op_r    <= BOOTH_NOP;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.product  = product_r;
    assign bus.booth_op = op_r;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Scoreboard bench for booth_seq_multiplier at WIDTH 8/32, radix-2/radix-4.
module tb_booth_seq_multiplier;
    import booth_pkg::*;

    localparam int NDUT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a [NDUT];
    logic        sgn_a   [NDUT];
    logic [31:0] mc_a    [NDUT];
    logic [31:0] mq_a    [NDUT];
    logic        busy_a  [NDUT];
    logic        done_a  [NDUT];
    logic [63:0] prod_a  [NDUT];
    logic [2:0]  bop_a   [NDUT];

    int width_t  [NDUT] = '{8, 8, 32, 32};
    int radix4_t [NDUT] = '{0, 1, 0, 1};
    int seen_mask[NDUT];

    int tests;
    int fails;
    logic [63:0] exp_q[$];

    booth_seq_multiplier_if #(.WIDTH(8))  if0 ();
    booth_seq_multiplier_if #(.WIDTH(8))  if1 ();
    booth_seq_multiplier_if #(.WIDTH(32)) if2 ();
    booth_seq_multiplier_if #(.WIDTH(32)) if3 ();

    booth_seq_multiplier #(.WIDTH(8),  .RADIX4(0)) u_w8r2  (.clk(clk), .rst_n(rst_n), .bus(if0));
    booth_seq_multiplier #(.WIDTH(8),  .RADIX4(1)) u_w8r4  (.clk(clk), .rst_n(rst_n), .bus(if1));
    booth_seq_multiplier #(.WIDTH(32), .RADIX4(0)) u_w32r2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    booth_seq_multiplier #(.WIDTH(32), .RADIX4(1)) u_w32r4 (.clk(clk), .rst_n(rst_n), .bus(if3));

    assign if0.start = start_a[0];  assign if0.op_signed = sgn_a[0];
    assign if0.multiplicand = mc_a[0][7:0];  assign if0.multiplier = mq_a[0][7:0];
    assign busy_a[0] = if0.busy;  assign done_a[0] = if0.done;
    assign prod_a[0] = {48'd0, if0.product};  assign bop_a[0] = if0.booth_op;

    assign if1.start = start_a[1];  assign if1.op_signed = sgn_a[1];
    assign if1.multiplicand = mc_a[1][7:0];  assign if1.multiplier = mq_a[1][7:0];
    assign busy_a[1] = if1.busy;  assign done_a[1] = if1.done;
    assign prod_a[1] = {48'd0, if1.product};  assign bop_a[1] = if1.booth_op;

    assign if2.start = start_a[2];  assign if2.op_signed = sgn_a[2];
    assign if2.multiplicand = mc_a[2];  assign if2.multiplier = mq_a[2];
    assign busy_a[2] = if2.busy;  assign done_a[2] = if2.done;
    assign prod_a[2] = if2.product;  assign bop_a[2] = if2.booth_op;

    assign if3.start = start_a[3];  assign if3.op_signed = sgn_a[3];
    assign if3.multiplicand = mc_a[3];  assign if3.multiplier = mq_a[3];
    assign busy_a[3] = if3.busy;  assign done_a[3] = if3.done;
    assign prod_a[3] = if3.product;  assign bop_a[3] = if3.booth_op;

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input int w, input logic sgn);
        longint sa;
        longint sb;
        logic [63:0] p;
        logic [63:0] mask;
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        p = 64'(sa * sb);
        if (w < 32) mask = (64'd1 << (2 * w)) - 64'd1;
        else        mask = {64{1'b1}};
        return p & mask;
    endfunction

    function automatic int lat_of(input int k);
        return ((radix4_t[k] != 0) ? (width_t[k] + 2) / 2 : width_t[k] + 2) + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] wm;
        wm = (width_t[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << width_t[k]) - 32'd1);
        mc_a[k] = a & wm;
        mq_a[k] = b & wm;
        sgn_a[k] = sgn;
        start_a[k] = 1'b1;
        exp_q.push_back(ref_prod(a & wm, b & wm, width_t[k], sgn));
        tick();
        start_a[k] = 1'b0;
    endtask

    // lat = cycles from the start cycle to the done cycle; 0 when done never came
    task automatic wait_done(input int k, output int lat);
        int e;
        e = 0;
        while (done_a[k] !== 1'b1 && e < 100) begin
            seen_mask[k] |= (1 << bop_a[k]);
            tick();
            e++;
        end
        lat = e + 1;
        if (done_a[k] !== 1'b1) begin
            tests++; fails++;
            $display("FAIL done_timeout k=%0d got no done within %0d cycles", k, e);
            lat = 0;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < NDUT; k++) begin
            tests++;
            if (busy_a[k] !== 1'b0 || done_a[k] !== 1'b0 || prod_a[k] !== 64'd0 || bop_a[k] !== 3'b000) begin
                fails++;
                $display("FAIL reset_state k=%0d got busy=%b done=%b prod=%h op=%b expected 0/0/0/000",
                         k, busy_a[k], done_a[k], prod_a[k], bop_a[k]);
            end
        end
    endtask

    task automatic test_basic_r2();
        int lat;
        logic [63:0] exp;
        issue(0, 32'hFFFF_FFFD, 32'd5, 1'b1);
        tests++;
        if (bop_a[0] !== 3'b101) begin
            fails++; $display("FAIL r2_first_op got %b expected 101", bop_a[0]);
        end
        wait_done(0, lat);
        exp = exp_q.pop_front();
        tests++;
        if (lat !== 11) begin fails++; $display("FAIL r2_latency got %0d expected 11", lat); end
        tests++;
        if (prod_a[0] !== exp || prod_a[0] !== 64'h0000_0000_0000_FFF1) begin
            fails++; $display("FAIL r2_product got %h expected %h", prod_a[0], 64'hFFF1);
        end
        tests++;
        if (busy_a[0] !== 1'b0) begin fails++; $display("FAIL r2_busy_in_done got %b expected 0", busy_a[0]); end
        tick();
        tests++;
        if (done_a[0] !== 1'b0 || bop_a[0] !== 3'b000 || prod_a[0] !== 64'h0000_0000_0000_FFF1) begin
            fails++; $display("FAIL r2_after_done got done=%b op=%b prod=%h expected 0/000/fff1",
                              done_a[0], bop_a[0], prod_a[0]);
        end
    endtask

    task automatic test_radix4_unsigned();
        int lat;
        logic [63:0] exp;
        issue(1, 32'hFF, 32'hFF, 1'b0);
        tests++;
        if (bop_a[1] !== 3'b101) begin fails++; $display("FAIL r4_first_op got %b expected 101", bop_a[1]); end
        wait_done(1, lat);
        exp = exp_q.pop_front();
        tests++;
        if (lat !== 6) begin fails++; $display("FAIL r4_latency got %0d expected 6", lat); end
        tests++;
        if (prod_a[1] !== exp || prod_a[1] !== 64'h0000_0000_0000_FE01) begin
            fails++; $display("FAIL r4_product got %h expected %h", prod_a[1], 64'hFE01);
        end
    endtask

    task automatic test_corners();
        logic [31:0] ca [3] = '{32'hFFFF_FF80, 32'd128, 32'd127};
        logic [31:0] cb [3] = '{32'hFFFF_FF80, 32'd128, 32'hFFFF_FF80};
        logic        cs [3] = '{1'b1, 1'b0, 1'b1};
        logic [63:0] cp [3] = '{64'h4000, 64'h4000, 64'hC080};
        int lat;
        logic [63:0] exp;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) begin
                issue(k, ca[i], cb[i], cs[i]);
                wait_done(k, lat);
                exp = exp_q.pop_front();
                tests++;
                if (prod_a[k] !== exp || prod_a[k] !== cp[i]) begin
                    fails++; $display("FAIL corner k=%0d i=%0d got %h expected %h", k, i, prod_a[k], cp[i]);
                end
            end
        end
    endtask

    task automatic test_start_mid_run(input int k);
        int lat;
        logic [63:0] exp;
        issue(k, 32'h0000_1234, 32'hFFFF_FF9C, 1'b1);
        tick();
        tick();
        mc_a[k] = 32'h7777_7777;
        mq_a[k] = 32'h5555_5555;
        sgn_a[k] = 1'b0;
        start_a[k] = 1'b1;
        tick();
        start_a[k] = 1'b0;
        wait_done(k, lat);
        exp = exp_q.pop_front();
        tests++;
        if (prod_a[k] !== exp) begin fails++; $display("FAIL mid_run_product k=%0d got %h expected %h", k, prod_a[k], exp); end
        tests++;
        if (lat !== lat_of(k) - 3) begin
            fails++; $display("FAIL mid_run_latency k=%0d got %0d expected %0d", k, lat + 3, lat_of(k));
        end
    endtask

    task automatic test_back_to_back(input int k);
        int lat;
        logic [63:0] exp1;
        logic [63:0] exp2;
        issue(k, 32'hDEAD_BEEF, 32'h0000_00C3, 1'b1);
        wait_done(k, lat);
        exp1 = exp_q.pop_front();
        tests++;
        if (prod_a[k] !== exp1) begin fails++; $display("FAIL b2b_first k=%0d got %h expected %h", k, prod_a[k], exp1); end
        issue(k, 32'h8000_0081, 32'hC0FF_EE11, 1'b0);
        tests++;
        if (busy_a[k] !== 1'b1 || prod_a[k] !== exp1) begin
            fails++; $display("FAIL b2b_no_gap k=%0d got busy=%b prod=%h expected 1/%h", k, busy_a[k], prod_a[k], exp1);
        end
        wait_done(k, lat);
        exp2 = exp_q.pop_front();
        tests++;
        if (prod_a[k] !== exp2 || lat !== lat_of(k)) begin
            fails++; $display("FAIL b2b_second k=%0d got %h lat %0d expected %h lat %0d",
                              k, prod_a[k], lat, exp2, lat_of(k));
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [63:0] exp;
        issue(2, 32'h0001_0003, 32'h0000_0777, 1'b0);
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        tests++;
        if (busy_a[2] !== 1'b0 || done_a[2] !== 1'b0 || prod_a[2] !== 64'd0) begin
            fails++; $display("FAIL async_reset got busy=%b done=%b prod=%h expected 0/0/0",
                              busy_a[2], done_a[2], prod_a[2]);
        end
        tick();
        rst_n = 1'b1;
        tick();
        issue(2, 32'hFFFF_FFF9, 32'h0000_0101, 1'b1);
        wait_done(2, lat);
        exp = exp_q.pop_front();
        tests++;
        if (prod_a[2] !== exp || lat !== lat_of(2)) begin
            fails++; $display("FAIL post_reset got %h lat %0d expected %h lat %0d", prod_a[2], lat, exp, lat_of(2));
        end
    endtask

    task automatic test_regression();
        int lat;
        logic [63:0] exp;
        logic [31:0] a;
        logic [31:0] b;
        for (int k = 0; k < NDUT; k++) begin
            for (int i = 0; i < 250; i++) begin
                a = $urandom();
                b = $urandom();
                issue(k, a, b, 1'($urandom_range(1, 0)));
                wait_done(k, lat);
                exp = exp_q.pop_front();
                tests++;
                if (prod_a[k] !== exp) begin
                    fails++; $display("FAIL regress k=%0d a=%h b=%h got %h expected %h", k, a, b, prod_a[k], exp);
                end
            end
        end
    endtask

    task automatic test_coverage();
        int want;
        for (int k = 0; k < NDUT; k++) begin
            want = (radix4_t[k] != 0) ? 32'h67 : 32'h23;
            tests++;
            if (seen_mask[k] !== want) begin
                fails++; $display("FAIL op_coverage k=%0d got %h expected %h", k, seen_mask[k], want);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int k = 0; k < NDUT; k++) begin
            start_a[k] = 1'b0;
            sgn_a[k] = 1'b0;
            mc_a[k] = 32'd0;
            mq_a[k] = 32'd0;
            seen_mask[k] = 0;
        end
        rst_n = 1'b0;
        tick();
        tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_basic_r2();
        test_radix4_unsigned();
        test_corners();
        test_start_mid_run(0);
        test_start_mid_run(3);
        test_back_to_back(1);
        test_back_to_back(2);
        test_reset_mid_run();
        test_regression();
        test_coverage();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
